// File: rtl/rca_pkg.sv
// Shared definitions for the sequential slice-by-slice ripple-carry adder.
package rca_pkg;
  localparam int unsigned N_DEF = 2;
  localparam int unsigned K_DEF = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/rca_seq_add_if.sv
// Operand/result handshake bundle for rca_seq_add.
interface rca_seq_add_if #(
  parameter int unsigned N = rca_pkg::N_DEF,
  parameter int unsigned K = rca_pkg::K_DEF
);
  localparam int unsigned W = N * K;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, op_a, op_b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, op_a, op_b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/rca_seq_add_rca.sv
// Combinational N-bit ripple-carry adder slice.
module rca_seq_add_rca #(
  parameter int unsigned N = rca_pkg::N_DEF
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] SUM,
  output logic         Cout
);
  logic [N:0] c;

  always_comb begin
    c    = '0;
    SUM  = '0;
    c[0] = Cin;
    for (int unsigned i = 0; i < N; i++) begin
      SUM[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    Cout = c[N];
  end
endmodule

// File: rtl/rca_seq_add.sv
// Multi-cycle W-bit adder: one N-bit slice per cycle through a single RCA instance.
module rca_seq_add
  import rca_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned K = K_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  rca_seq_add_if.slave bus
);
  localparam int unsigned IW = $clog2(K);
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  state_e                  state_q;
  logic [IW-1:0]           idx_q;
  logic [K-1:0][N-1:0]     a_q, b_q, sum_q;
  logic                    carry_q, cout_q, ovf_q;
  logic                    in_ready_q, out_valid_q;

  logic [N-1:0]            sl_sum;
  logic                    sl_cout;

  rca_seq_add_rca #(.N(N)) rca (
    .A    (a_q[idx_q]),
    .B    (b_q[idx_q]),
    .Cin  (carry_q),
    .SUM  (sl_sum),
    .Cout (sl_cout)
  );

  // Index stops at LAST instead of wrapping; the DONE transition owns the final slice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.op_a;
            b_q        <= bus.op_b;
            carry_q    <= bus.cin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q] <= sl_sum;
          carry_q      <= sl_cout;
          if (idx_q == LAST) begin
            cout_q      <= sl_cout;
            ovf_q       <= (a_q[K-1][N-1] == b_q[K-1][N-1]) &&
                           (sl_sum[N-1] != a_q[K-1][N-1]);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_rca_seq_add.sv
// Directed and random checks of rca_seq_add with N=2, K=4 (W=8).
module tb_rca_seq_add;
  import rca_pkg::*;

  localparam int N = 2;
  localparam int K = 4;
  localparam int W = N * K;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rca_seq_add_if #(.N(N), .K(K)) bus ();

  rca_seq_add #(.N(N), .K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, ovf, sum} from a plain W-bit addition.
  function automatic logic [9:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] t;
    logic       ov;
    t  = 9'(a) + 9'(b) + 9'(c);
    ov = (a[7] == b[7]) && (t[7] != a[7]);
    return {t[8], ov, t[7:0]};
  endfunction

  // One transaction; latency counts cycles after the accept cycle up to the first out_valid cycle.
  task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] es, input logic eco, input logic eov,
                         input int hold, input bit poke);
    int cnt;
    @(negedge clk);
    cnt = 0;
    while (!bus.in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, " in_ready"}, 16'(bus.in_ready), 16'd1);
    bus.in_valid  = 1'b1;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.cin       = c;
    bus.out_ready = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (poke) begin
        bus.in_valid  = 1'b1;
        bus.op_a      = ~a;
        bus.op_b      = 8'hA5;
        bus.cin       = ~c;
        bus.out_ready = !bus.out_valid;
      end else begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
      end
    end while (!bus.out_valid && cnt < 20);
    chk({tag, " latency"}, 16'(cnt), 16'(K + 1));
    chk({tag, " sum"}, 16'(bus.sum), 16'(es));
    chk({tag, " cout"}, 16'(bus.cout), 16'(eco));
    chk({tag, " ovf"}, 16'(bus.ovf), 16'(eov));
    chk({tag, " busy"}, 16'(bus.in_ready), 16'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, 16'(bus.out_valid), 16'd1);
      chk({tag, " hold sum"}, 16'(bus.sum), 16'(es));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, " idle ready"}, 16'(bus.in_ready), 16'd1);
    chk({tag, " idle valid"}, 16'(bus.out_valid), 16'd0);
    chk({tag, " idle sum"}, 16'(bus.sum), 16'(es));
  endtask

  initial begin
    int cyc, last_acc, issued, got;
    logic [7:0] ra, rb;
    logic       rc;
    logic [9:0] exp_q[$];
    logic [9:0] e;

    // Reset wins over a simultaneous operand offer.
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op_a      = 8'h3C;
    bus.op_b      = 8'hC3;
    bus.cin       = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", 16'(bus.in_ready), 16'd1);
    chk("rst out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst sum", 16'(bus.sum), 16'd0);
    chk("rst cout", 16'(bus.cout), 16'd0);
    chk("rst ovf", 16'(bus.ovf), 16'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b1;

    run_txn("0F+01",    8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0, 1'b0);
    run_txn("FF+01",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    run_txn("FF+00+c",  8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    run_txn("7F+01",    8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, 1'b0);
    run_txn("80+80",    8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0);
    run_txn("hold90+A0", 8'h90, 8'hA0, 1'b0, 8'h30, 1'b1, 1'b1, 10, 1'b1);

    // Abort in the second RUN cycle; previous result (30, cout=1, ovf=1) must be cleared.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_a     = 8'h33;
    bus.op_b     = 8'h44;
    bus.cin      = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort in_ready", 16'(bus.in_ready), 16'd1);
    chk("abort out_valid", 16'(bus.out_valid), 16'd0);
    chk("abort sum", 16'(bus.sum), 16'd0);
    chk("abort cout", 16'(bus.cout), 16'd0);
    chk("abort ovf", 16'(bus.ovf), 16'd0);
    rst_n = 1'b1;
    run_txn("12+34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0, 1'b0);

    // Random back-to-back traffic with random consumer stalls.
    cyc      = 0;
    last_acc = -1;
    issued   = 0;
    got      = 0;
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && bus.out_ready) begin
        chk("rnd result expected", 16'(exp_q.size() != 0), 16'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rnd result", 16'({bus.cout, bus.ovf, bus.sum}), 16'(e));
        end
        got++;
      end
      if (bus.in_ready && issued < 1000) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        rc = 1'($urandom_range(0, 1));
        bus.in_valid = 1'b1;
        bus.op_a     = ra;
        bus.op_b     = rb;
        bus.cin      = rc;
        exp_q.push_back(ref_add(ra, rb, rc));
        if (last_acc >= 0)
          chk("rnd accept gap", 16'((cyc - last_acc) >= K + 2), 16'd1);
        last_acc = cyc;
        issued++;
      end else begin
        bus.in_valid = bus.in_ready ? 1'b0 : 1'($urandom_range(0, 1));
        bus.op_a     = 8'($urandom);
        bus.op_b     = 8'($urandom);
        bus.cin      = 1'($urandom_range(0, 1));
      end
    end
    chk("rnd within budget", 16'(cyc < 20000), 16'd1);
    chk("rnd results seen", 16'(got), 16'd1000);
    chk("rnd none left", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
